// File: rtl/addsub_pkg.sv
// addsub_pkg
// Shared constants and types for the nibble-serial add/sub sequencer.
//   NIBBLE_W        width of one arithmetic slice
//   addsub_state_e  controller state encoding (IDLE, RUN, DONE)
//   SUB_BORROW_INV  borrow is reported as the inverted final carry on subtract
package addsub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } addsub_state_e;

  // Subtract runs as a + ~b + 1, so a final carry of 1 means "no borrow".
  localparam logic SUB_BORROW_INV = 1'b1;

endpackage

// File: rtl/addsub_nibble.sv
// addsub_nibble
// Combinational 4-bit add/subtract slice.
//   a, b   in   4-bit operand nibbles (b is inverted when sub=1)
//   cin    in   carry in from the previous slice
//   sub    in   0 = add, 1 = subtract
//   s      out  4-bit sum
//   cout   out  carry out of bit 3
//   c3     out  carry into bit 3 (signed-overflow detection)
import addsub_pkg::*;

module addsub_nibble (
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  input  logic                sub,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout,
  output logic                c3
);

  logic [NIBBLE_W-1:0] bx;

  assign bx = sub ? ~b : b;

  // Split at bit 3 so the carry into the MSB is available for overflow.
  assign {c3, s[2:0]} = {1'b0, a[2:0]} + {1'b0, bx[2:0]} + {3'b000, cin};
  assign {cout, s[3]} = {1'b0, a[3]} + {1'b0, bx[3]} + {1'b0, c3};

endmodule

// File: rtl/multi_nibble_addsub_ctrl.sv
// multi_nibble_addsub_ctrl
// Runs a W = 4*NIBBLES bit add or subtract through one 4-bit slice,
// least significant nibble first, one nibble per clock.
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   start  in   request, sampled only while ready=1
//   sub    in   0 = add, 1 = subtract (latched with start)
//   a, b   in   W-bit operands (latched with start)
//   ready  out  high in IDLE only
//   done   out  one-cycle pulse when f and flags update
//   f      out  W-bit result, held until the next done
//   cf     out  carry (add) / borrow (subtract)
//   zf     out  result is zero
//   vf     out  signed overflow, present only when ADDSUB_OVF_EN is defined
//
// state | meaning
// IDLE  | waiting for start, ready=1
// RUN   | one nibble per cycle, NIBBLES cycles
// DONE  | result/flags just written, done=1 for this cycle
import addsub_pkg::*;

module multi_nibble_addsub_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      sub,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  output logic                      ready,
  output logic                      done,
  output logic [NIBBLE_W*NIBBLES-1:0] f,
  output logic                      cf,
`ifdef ADDSUB_OVF_EN
  output logic                      vf,
`endif
  output logic                      zf
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]          state;
  logic [IDX_W-1:0]    idx;
  logic                carry;
  logic                sub_r;
  logic [W-1:0]        a_sh;
  logic [W-1:0]        b_sh;
  // Holds the NIBBLES-1 nibbles finished so far; the last one goes straight to f.
  logic [W-NIBBLE_W-1:0] res_sh;

  logic [NIBBLE_W-1:0] slice_s;
  logic                slice_cout;
  logic                slice_c3;
  logic [W-1:0]        res_next;

  addsub_nibble u_slice (
    .a    (a_sh[NIBBLE_W-1:0]),
    .b    (b_sh[NIBBLE_W-1:0]),
    .cin  (carry),
    .sub  (sub_r),
    .s    (slice_s),
    .cout (slice_cout),
    .c3   (slice_c3)
  );

  assign res_next = {slice_s, res_sh};
  assign ready    = (state == S_IDLE);

`ifndef ADDSUB_OVF_EN
  logic slice_c3_unused;
  assign slice_c3_unused = slice_c3;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      sub_r  <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      done   <= 1'b0;
      f      <= '0;
      cf     <= 1'b0;
      zf     <= 1'b0;
`ifdef ADDSUB_OVF_EN
      vf     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            a_sh  <= a;
            b_sh  <= b;
            sub_r <= sub;
            carry <= sub;
            idx   <= '0;
          end
        end
        S_RUN: begin
          a_sh   <= a_sh >> NIBBLE_W;
          b_sh   <= b_sh >> NIBBLE_W;
          carry  <= slice_cout;
          res_sh <= res_next[W-1:NIBBLE_W];
          idx    <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state <= S_DONE;
            done  <= 1'b1;
            f     <= res_next;
            cf    <= slice_cout ^ (sub_r & SUB_BORROW_INV);
            zf    <= (res_next == '0);
`ifdef ADDSUB_OVF_EN
            vf    <= slice_c3 ^ slice_cout;
`endif
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_nibble_addsub_ctrl.sv
module tb_multi_nibble_addsub_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready, done, cf, zf;
  logic [W-1:0] f;
`ifdef ADDSUB_OVF_EN
  logic         vf;
`endif

  multi_nibble_addsub_ctrl #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .ready (ready),
    .done  (done),
    .f     (f),
    .cf    (cf),
`ifdef ADDSUB_OVF_EN
    .vf    (vf),
`endif
    .zf    (zf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] f;
    logic         cf;
    logic         zf;
    logic         vf;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int n_acc    = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the full operands.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    exp_t   e;
    longint ux = longint'(x);
    longint uy = longint'(y);
    longint full;
    full = s ? (ux - uy) : (ux + uy);
    e.f  = W'(full);
    e.cf = s ? (ux < uy) : (full >= (64'sd1 <<< W));
    e.zf = (e.f == '0);
    if (s) e.vf = (x[W-1] != y[W-1]) && (e.f[W-1] != x[W-1]);
    else   e.vf = (x[W-1] == y[W-1]) && (e.f[W-1] != x[W-1]);
    return e;
  endfunction

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      n_done++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: done pulse with no accepted request (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        check("f", f, e.f);
        check("cf", cf, e.cf);
        check("zf", zf, e.zf);
`ifdef ADDSUB_OVF_EN
        check("vf", vf, e.vf);
`endif
      end
    end
  end

  task automatic wait_ready(output bit ok);
    int waited = 0;
    @(negedge clk);
    while (!ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    ok = ready;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: ready stayed 0 for %0d cycles", waited);
    end
  endtask

  // One transaction with cycle-accurate timing checks. poke_run pulses start
  // with different operands during RUN; abort_at>0 asserts rst in that RUN cycle.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                       input bit poke_run, input int abort_at);
    bit   ok;
    exp_t e;
    wait_ready(ok);
    if (!ok) return;
    e = model(x, y, s);
    a = x; b = y; sub = s; start = 1'b1;
    sb.push_back(e);
    n_acc++;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    check("ready_low_after_accept", ready, 0);
    for (int c = 1; c <= N; c++) begin
      @(posedge clk); #1;
      if (abort_at == c) begin
        rst = 1'b1;
        #1;
        void'(sb.pop_back());
        n_acc--;
        check("abort_ready", ready, 1);
        check("abort_done", done, 0);
        check("abort_f", f, 0);
        check("abort_cf", cf, 0);
        check("abort_zf", zf, 0);
`ifdef ADDSUB_OVF_EN
        check("abort_vf", vf, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (poke_run) begin
        start = (c == 1);
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
      end
      check("done_timing", done, (c == N));
      check("ready_during_run", ready, 0);
    end
    start = 1'b0;
    @(posedge clk); #1;
    check("ready_back", ready, 1);
    check("done_one_cycle", done, 0);
    check("f_hold", f, e.f);
  endtask

  initial begin
    bit ok;
    int last_acc;

    repeat (2) @(negedge clk);
    #1;
    check("reset_ready", ready, 1);
    check("reset_done", done, 0);
    check("reset_f", f, 0);
    check("reset_cf", cf, 0);
    check("reset_zf", zf, 0);
`ifdef ADDSUB_OVF_EN
    check("reset_vf", vf, 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    issue(16'h1234, 16'h0FFF, 1'b0, 1'b0, 0);
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    issue(16'h0005, 16'h0007, 1'b1, 1'b0, 0);
    issue(16'h8000, 16'h8000, 1'b1, 1'b0, 0);
    issue(16'h1111, 16'h2222, 1'b0, 1'b1, 0);
    issue(16'h4321, 16'h1234, 1'b0, 1'b0, 2);
    repeat (N + 3) @(negedge clk);
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    issue(16'h8000, 16'h0001, 1'b1, 1'b0, 0);

    for (int i = 0; i < 20; i++)
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), 0);

    // start held high: accepted at every ready edge, one issue interval apart
    last_acc = -1;
    start = 1'b1;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    for (int i = 0; i < 5; i++) begin
      wait_ready(ok);
      if (!ok) break;
      sb.push_back(model(a, b, sub));
      n_acc++;
      @(posedge clk);
      if (last_acc >= 0) check("issue_interval", cyc - last_acc, N + 2);
      last_acc = cyc;
      #1;
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (N + 4) @(negedge clk);

    check("done_count", n_done, n_acc);
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
